uart_axil_ctrl: RTL and testbench
=================================

// Module: uart_axil_ctrl
// PURPOSE
//  AXI4-Lite slave controller that sequences the UART core: decodes register accesses on
//  S_AXI_*, pops RX FIFO / pushes TX FIFO with single-cycle strobes, holds control/status,
//  raises Interrupt. Sits between the AXI interconnect and UART (FIFOs + serializers).
// PARAMETERS
//  C_S_AXI_ADDR_WIDTH   4    AXI address width; only addr[3:2] decoded, addr[1:0] ignored
//  C_S_AXI_DATA_WIDTH   32   AXI data width; must be 32
//  C_DATA_BITS          8    UART character width (RX_data/TX_data)
// PORTS
//  S_AXI_ACLK     in   1     clock; UART runs on same clock
//  S_AXI_ARESETN  in   1     asynchronous active-low reset
//  S_AXI_AWADDR   in   4     write address      | S_AXI_AWVALID in 1 | S_AXI_AWREADY out 1
//  S_AXI_WDATA    in   32    write data         | S_AXI_WSTRB   in 4 | S_AXI_WVALID in 1 | S_AXI_WREADY out 1
//  S_AXI_BRESP    out  2     write response     | S_AXI_BVALID out 1 | S_AXI_BREADY in 1
//  S_AXI_ARADDR   in   4     read address       | S_AXI_ARVALID in 1 | S_AXI_ARREADY out 1
//  S_AXI_RDATA    out  32    read data          | S_AXI_RRESP out 2  | S_AXI_RVALID out 1 | S_AXI_RREADY in 1
//  RX_data        in   8     RX FIFO head (first-word-fall-through, valid when !Empty)
//  Empty          in   1     RX FIFO empty
//  rd_uart_en     out  1     1-cycle RX FIFO pop
//  TX_data        out  8     TX FIFO write data, valid with wr_uart_en
//  wr_uart_en     out  1     1-cycle TX FIFO push
//  Full           in   1     TX FIFO full
//  TX_empty       in   1     TX FIFO empty
//  rst_rx_fifo    out  1     1-cycle RX FIFO clear | rst_tx_fifo out 1  1-cycle TX FIFO clear
//  Enable_rx      out  1     RX enable (CTRL[2])   | Enable_tx   out 1  TX enable (CTRL[3])
//  Interrupt      out  1     1-cycle interrupt pulse
// BEHAVIOUR
//  Reset: all VALID/READY, strobes, Interrupt, RDATA, RRESP, BRESP = 0; CTRL = 0x0C (both enables on, intr off).
//  Reg map: 0x0 RXFIFO (RO), 0x4 TXFIFO (WO), 0x8 STAT (RO), 0xC CTRL (WO, bits 0/1 self-clearing).
//  Write FSM W_IDLE->W_RESP: in W_IDLE, AWREADY=WREADY=1 for one cycle only when AWVALID&&WVALID (cycle N).
//   Cycle N+1: BVALID=1 and side effect strobes fire (registered); hold BVALID until BREADY, then W_IDLE.
//   0x4: if WSTRB[0] && !Full -> wr_uart_en=1, TX_data=WDATA[7:0], OKAY; if Full -> no push, SLVERR(2'b10).
//   0xC: if WSTRB[0]: rst_tx_fifo=WDATA[0], rst_rx_fifo=WDATA[1], CTRL[4:2]=WDATA[4:2]; OKAY.
//   0x0/0x8 write: no effect, SLVERR. WSTRB[0]=0 on any reg: no effect, OKAY.
//  Read FSM R_IDLE->R_RESP: ARREADY=1 in R_IDLE; on handshake (cycle N) RDATA/RRESP register at N+1, RVALID=1.
//   0x0: if !Empty -> RDATA={24'b0,RX_data}, rd_uart_en=1 in cycle N+1 only, OKAY; Empty -> RDATA=0, SLVERR.
//   0x8 STAT: [0]=!Empty [2]=TX_empty [3]=Full [4]=CTRL[4]; others 0. OKAY. 0x4/0xC read: RDATA=0, SLVERR.
//   RDATA/RRESP stable while RVALID && !RREADY; return to R_IDLE on RREADY.
//  Read and write channels independent; both may complete same cycle. RX pop and rst_rx_fifo same
//   cycle allowed: returned data is the sampled head, FIFO ends empty.
//  Interrupt: when CTRL[4]=1, 1-cycle pulse on rising edge of !Empty or rising edge of TX_empty
//   (edges tracked continuously; enabling CTRL[4] while condition already true does not pulse).
//  Reset mid-transaction: FSMs to IDLE, pending responses dropped, no strobe issued.
//  Strobe outputs are never asserted for more than 1 consecutive cycle per transaction.
// STRUCTURE
//  uart_axil_pkg: register offsets, STAT/CTRL bit indices, RESP_OKAY/RESP_SLVERR, w_state_t/r_state_t enums.
//  Sub-module uart_irq_gen: edge detect of rx_valid/tx_empty gated by intr_en -> Interrupt.
// TESTING
//  1 Reset: ARESETN=0 mid write -> BVALID=0, wr_uart_en=0; after release read 0x8 -> RDATA=0x04 (TX_empty=1).
//  2 Write 0x4 WDATA=0x55 Full=0 -> wr_uart_en=1 one cycle, TX_data=0x55, BRESP=OKAY; Full=1 -> no push, BRESP=2.
//  3 Empty=0 RX_data=0x81, read 0x0 with RREADY low 3 cycles -> RDATA=0x81 stable, rd_uart_en exactly 1 pulse.
//  4 Read 0x0 with Empty=1 -> RDATA=0, RRESP=2'b10, rd_uart_en=0.
//  5 Write 0xC=0x13 -> rst_tx_fifo,rst_rx_fifo 1 pulse, Enable_rx=Enable_tx=0; Empty 1->0 -> Interrupt 1 pulse.
//  6 Simultaneous AW/W and AR to 0x4/0x8 same cycle -> both complete, BVALID and RVALID at N+1.

Source files
------------

// File: rtl/uart_axil_pkg.sv
// Shared definitions for the UART AXI4-Lite controller: register map, bit positions,
// response codes and the write/read channel state types.
package uart_axil_pkg;

  localparam logic [1:0] REG_RXFIFO = 2'd0;
  localparam logic [1:0] REG_TXFIFO = 2'd1;
  localparam logic [1:0] REG_STAT   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_INTR_EN  = 4;

  localparam int CTRL_RST_TX  = 0;
  localparam int CTRL_RST_RX  = 1;
  localparam int CTRL_EN_RX   = 2;
  localparam int CTRL_EN_TX   = 3;
  localparam int CTRL_INTR_EN = 4;

  // Only CTRL[4:2] are stored; bits 1:0 are fire-and-forget clear strobes.
  localparam logic [4:2] CTRL_RESET = 3'b011;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_t;

endpackage

// File: rtl/uart_axil_ctrl_if.sv
// AXI4-Lite slave bus bundle for the UART controller.
// Handshake: a beat transfers on a rising edge where VALID and READY are both high; a source
// never waits for READY before raising VALID and holds its payload stable until the transfer.
interface uart_axil_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/uart_irq_gen.sv
// Interrupt pulse generator: one-cycle pulse on a rising edge of rx_valid or tx_empty while
// enabled. Edges are tracked every cycle so enabling over an already-true level does not fire.
module uart_irq_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_valid_i,
  input  logic tx_empty_i,
  input  logic intr_en_i,
  output logic irq_o
);
  logic rx_valid_q;
  logic tx_empty_q;
  logic irq_q, irq_d;

  assign irq_d = intr_en_i && ((rx_valid_i && !rx_valid_q) || (tx_empty_i && !tx_empty_q));
  assign irq_o = irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      tx_empty_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_i;
      tx_empty_q <= tx_empty_i;
      irq_q      <= irq_d;
    end
  end
endmodule

// File: rtl/uart_axil_ctrl.sv
// AXI4-Lite register front end of the UART: independent write and read channel FSMs,
// single-cycle FIFO push/pop/clear strobes, CTRL/STAT registers and the interrupt pulse.
module uart_axil_ctrl
  import uart_axil_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_DATA_BITS        = 8
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  uart_axil_ctrl_if.slave        s_axi,
  input  logic [C_DATA_BITS-1:0] RX_data,
  input  logic                   Empty,
  output logic                   rd_uart_en,
  output logic [C_DATA_BITS-1:0] TX_data,
  output logic                   wr_uart_en,
  input  logic                   Full,
  input  logic                   TX_empty,
  output logic                   rst_rx_fifo,
  output logic                   rst_tx_fifo,
  output logic                   Enable_rx,
  output logic                   Enable_tx,
  output logic                   Interrupt,
  output w_state_t               w_state_o,
  output r_state_t               r_state_o
);
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata;
  logic [1:0]                    w_sel, r_sel;
  logic                          w_hs, r_hs;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic [1:0]                    bresp_q, bresp_d;
  logic                          wr_en_q, wr_en_d;
  logic [C_DATA_BITS-1:0]        tx_data_q, tx_data_d;
  logic                          rst_tx_q, rst_tx_d;
  logic                          rst_rx_q, rst_rx_d;
  logic [4:2]                    ctrl_q, ctrl_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic                          rd_en_q, rd_en_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] stat;
  logic                          unused_bits;

  assign awaddr = s_axi.S_AXI_AWADDR;
  assign araddr = s_axi.S_AXI_ARADDR;
  assign wdata  = s_axi.S_AXI_WDATA;
  assign w_sel  = awaddr[3:2];
  assign r_sel  = araddr[3:2];
  assign unused_bits = ^{awaddr[1:0], araddr[1:0], wdata[C_S_AXI_DATA_WIDTH-1:C_DATA_BITS],
                         s_axi.S_AXI_WSTRB[3:1]};

  // A write is accepted only when address and data arrive together.
  assign w_hs = (w_state_q == W_IDLE) && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
  assign r_hs = (r_state_q == R_IDLE) && s_axi.S_AXI_ARVALID;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    case (w_state_q)
      W_IDLE:  if (w_hs) w_state_d = W_RESP;
      W_RESP:  if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    case (r_state_q)
      R_IDLE:  if (r_hs) r_state_d = R_RESP;
      R_RESP:  if (s_axi.S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Readies are held low while reset is asserted even though the FSMs sit in IDLE.
  always_comb begin
    s_axi.S_AXI_AWREADY = S_AXI_ARESETN && w_hs;
    s_axi.S_AXI_WREADY  = S_AXI_ARESETN && w_hs;
    s_axi.S_AXI_BVALID  = (w_state_q == W_RESP);
    s_axi.S_AXI_ARREADY = S_AXI_ARESETN && (r_state_q == R_IDLE);
    s_axi.S_AXI_RVALID  = (r_state_q == R_RESP);
  end

  always_comb begin
    bresp_d   = bresp_q;
    wr_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    rst_tx_d  = 1'b0;
    rst_rx_d  = 1'b0;
    ctrl_d    = ctrl_q;
    if (w_hs) begin
      bresp_d = RESP_OKAY;
      if (s_axi.S_AXI_WSTRB[0]) begin
        case (w_sel)
          REG_TXFIFO: begin
            if (Full) begin
              bresp_d = RESP_SLVERR;
            end else begin
              wr_en_d   = 1'b1;
              tx_data_d = wdata[C_DATA_BITS-1:0];
            end
          end
          REG_CTRL: begin
            rst_tx_d = wdata[CTRL_RST_TX];
            rst_rx_d = wdata[CTRL_RST_RX];
            ctrl_d   = wdata[4:2];
          end
          default: bresp_d = RESP_SLVERR;
        endcase
      end
    end
  end

  always_comb begin
    stat                = '0;
    stat[STAT_RX_VALID] = !Empty;
    stat[STAT_TX_EMPTY] = TX_empty;
    stat[STAT_TX_FULL]  = Full;
    stat[STAT_INTR_EN]  = ctrl_q[CTRL_INTR_EN];
  end

  // Read payload is captured once at the address handshake and then held until RREADY.
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rd_en_d = 1'b0;
    if (r_hs) begin
      rdata_d = '0;
      rresp_d = RESP_OKAY;
      case (r_sel)
        REG_RXFIFO: begin
          if (!Empty) begin
            rdata_d[C_DATA_BITS-1:0] = RX_data;
            rd_en_d                  = 1'b1;
          end else begin
            rresp_d = RESP_SLVERR;
          end
        end
        REG_STAT: rdata_d = stat;
        default:  rresp_d = RESP_SLVERR;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bresp_q   <= RESP_OKAY;
      wr_en_q   <= 1'b0;
      tx_data_q <= '0;
      rst_tx_q  <= 1'b0;
      rst_rx_q  <= 1'b0;
      ctrl_q    <= CTRL_RESET;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rd_en_q   <= 1'b0;
    end else begin
      bresp_q   <= bresp_d;
      wr_en_q   <= wr_en_d;
      tx_data_q <= tx_data_d;
      rst_tx_q  <= rst_tx_d;
      rst_rx_q  <= rst_rx_d;
      ctrl_q    <= ctrl_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rd_en_q   <= rd_en_d;
    end
  end

  assign s_axi.S_AXI_BRESP = bresp_q;
  assign s_axi.S_AXI_RDATA = rdata_q;
  assign s_axi.S_AXI_RRESP = rresp_q;
  assign wr_uart_en  = wr_en_q;
  assign TX_data     = tx_data_q;
  assign rd_uart_en  = rd_en_q;
  assign rst_tx_fifo = rst_tx_q;
  assign rst_rx_fifo = rst_rx_q;
  assign Enable_rx   = ctrl_q[CTRL_EN_RX];
  assign Enable_tx   = ctrl_q[CTRL_EN_TX];
  assign w_state_o   = w_state_q;
  assign r_state_o   = r_state_q;

  uart_irq_gen u_irq (
    .clk        (S_AXI_ACLK),
    .rst_n      (S_AXI_ARESETN),
    .rx_valid_i (!Empty),
    .tx_empty_i (TX_empty),
    .intr_en_i  (ctrl_q[CTRL_INTR_EN]),
    .irq_o      (Interrupt)
  );
endmodule

// File: tb/tb_uart_axil_ctrl.sv
// Directed and randomized checks of the UART AXI4-Lite controller against a register-level
// reference model held in the bench.
module tb_uart_axil_ctrl;
  import uart_axil_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data, tx_data;
  logic       empty, rd_en, wr_en, full, tx_empty;
  logic       rst_rx, rst_tx, en_rx, en_tx, irq;
  w_state_t   w_dbg;
  r_state_t   r_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // model of the stored control bits
  logic m_en_rx, m_en_tx, m_intr;

  always #5 clk = ~clk;

  uart_axil_ctrl_if bus ();

  uart_axil_ctrl dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus.slave),
    .RX_data       (rx_data),
    .Empty         (empty),
    .rd_uart_en    (rd_en),
    .TX_data       (tx_data),
    .wr_uart_en    (wr_en),
    .Full          (full),
    .TX_empty      (tx_empty),
    .rst_rx_fifo   (rst_rx),
    .rst_tx_fifo   (rst_tx),
    .Enable_rx     (en_rx),
    .Enable_tx     (en_tx),
    .Interrupt     (irq),
    .w_state_o     (w_dbg),
    .r_state_o     (r_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one AW+W beat, then watch three cycles starting at the response cycle.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic ok, output logic b_n1, output logic [1:0] resp,
                           output int n_wr, output logic [7:0] txd, output int n_rtx,
                           output int n_rrx);
    ok = 1'b0; b_n1 = 1'b0; resp = 2'b00; n_wr = 0; txd = 8'h00; n_rtx = 0; n_rrx = 0;
    @(posedge clk); #1;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.S_AXI_AWREADY && bus.S_AXI_WREADY) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        b_n1 = bus.S_AXI_BVALID;
        resp = bus.S_AXI_BRESP;
      end
      if (wr_en) begin n_wr++; txd = tx_data; end
      if (rst_tx) n_rtx++;
      if (rst_rx) n_rrx++;
    end
  endtask

  // Read with RREADY held low for 'hold' cycles of the response; checks payload stability.
  task automatic axi_read(input logic [3:0] addr, input int hold,
                          output logic ok, output logic r_n1, output logic [31:0] data,
                          output logic [1:0] resp, output int n_rd, output logic stable,
                          output logic done);
    ok = 1'b0; r_n1 = 1'b0; data = '0; resp = 2'b00; n_rd = 0; stable = 1'b1; done = 1'b0;
    @(posedge clk); #1;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = (hold == 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.S_AXI_ARREADY) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    r_n1 = bus.S_AXI_RVALID;
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    if (rd_en) n_rd++;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      if (c == hold - 1) bus.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      if (bus.S_AXI_RDATA !== data || bus.S_AXI_RRESP !== resp || !bus.S_AXI_RVALID) stable = 1'b0;
      if (rd_en) n_rd++;
    end
    @(negedge clk);
    if (rd_en) n_rd++;
    done = !bus.S_AXI_RVALID;
  endtask

  initial begin
    logic        ok, b_n1, r_n1, stable, done, hs_ok, bv, p_empty, p_txe, exp_irq;
    logic        exp_push, exp_rtx, exp_rrx;
    logic [1:0]  resp, exp_resp;
    logic [7:0]  txd;
    logic [31:0] data, wd, exp_data;
    logic [3:0]  addr, strb;
    int          n_wr, n_rtx, n_rrx, n_rd, n, hold;

    // clock/reset and idle bus
    rst_n = 1'b0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB   = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    rx_data = 8'h00; empty = 1'b1; full = 1'b0; tx_empty = 1'b1;
    m_en_rx = 1'b1; m_en_tx = 1'b1; m_intr = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    check("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    check("rst_strobes", 32'({wr_en, rd_en, rst_tx, rst_rx, irq}), 32'd0);
    check("rst_enables", 32'({en_rx, en_tx}), 32'b11);
    check("rst_resp",    32'({bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 32'd0);
    check("rst_rdata",   bus.S_AXI_RDATA, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: STAT after reset, then reset landing inside a write
    axi_read(4'h8, 0, ok, r_n1, data, resp, n_rd, stable, done);
    check("t1_stat_data", data, 32'h04);
    check("t1_stat_resp", 32'(resp), 32'(RESP_OKAY));

    @(posedge clk); #1;
    bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_WDATA = 32'hAA; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    check("t1_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    #2 rst_n = 1'b0;
    n = 0; bv = 1'b0;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wr_en) n++;
      if (bus.S_AXI_BVALID) bv = 1'b1;
    end
    check("t1_midrst_push",   32'(n),     32'd0);
    check("t1_midrst_bvalid", 32'(bv),    32'd0);
    check("t1_midrst_wstate", 32'(w_dbg), 32'(W_IDLE));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t1_enables", 32'({en_rx, en_tx}), 32'b11);

    // 2: TX push, then push against a full FIFO
    axi_write(4'h4, 32'h55, 4'hF, ok, b_n1, resp, n_wr, txd, n_rtx, n_rrx);
    check("t2_hs",      32'(ok),   32'd1);
    check("t2_bvalid",  32'(b_n1), 32'd1);
    check("t2_bresp",   32'(resp), 32'(RESP_OKAY));
    check("t2_pushes",  32'(n_wr), 32'd1);
    check("t2_tx_data", 32'(txd),  32'h55);
    full = 1'b1;
    axi_write(4'h4, 32'h66, 4'hF, ok, b_n1, resp, n_wr, txd, n_rtx, n_rrx);
    check("t2_full_bresp",  32'(resp), 32'(RESP_SLVERR));
    check("t2_full_pushes", 32'(n_wr), 32'd0);
    full = 1'b0;

    // 3: RX pop with a stalled response
    empty = 1'b0; rx_data = 8'h81;
    axi_read(4'h0, 3, ok, r_n1, data, resp, n_rd, stable, done);
    check("t3_rvalid", 32'(r_n1),   32'd1);
    check("t3_rdata",  data,        32'h81);
    check("t3_rresp",  32'(resp),   32'(RESP_OKAY));
    check("t3_stable", 32'(stable), 32'd1);
    check("t3_pops",   32'(n_rd),   32'd1);
    check("t3_done",   32'(done),   32'd1);

    // 4: RX read while empty
    empty = 1'b1;
    axi_read(4'h0, 0, ok, r_n1, data, resp, n_rd, stable, done);
    check("t4_rdata", data,      32'h0);
    check("t4_rresp", 32'(resp), 32'(RESP_SLVERR));
    check("t4_pops",  32'(n_rd), 32'd0);

    // 5: CTRL write with clears, enables off, interrupt on
    axi_write(4'hC, 32'h13, 4'hF, ok, b_n1, resp, n_wr, txd, n_rtx, n_rrx);
    m_en_rx = 1'b0; m_en_tx = 1'b0; m_intr = 1'b1;
    check("t5_bresp",   32'(resp),  32'(RESP_OKAY));
    check("t5_rst_tx",  32'(n_rtx), 32'd1);
    check("t5_rst_rx",  32'(n_rrx), 32'd1);
    check("t5_enables", 32'({en_rx, en_tx}), 32'b00);
    n = 0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (irq) n++; end
    check("t5_no_level_irq", 32'(n), 32'd0);
    @(posedge clk); #1 empty = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (irq) n++; end
    check("t5_irq_pulses", 32'(n), 32'd1);
    axi_read(4'h8, 0, ok, r_n1, data, resp, n_rd, stable, done);
    check("t5_stat", data, 32'h15);

    // 6: write and read accepted on the same edge
    @(posedge clk); #1;
    bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_WDATA = 32'h3C; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 4'h8; bus.S_AXI_ARVALID = 1'b1;
    hs_ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.S_AXI_AWREADY && bus.S_AXI_ARREADY) begin hs_ok = 1'b1; break; end
    end
    check("t6_hs", 32'(hs_ok), 32'd1);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    check("t6_valids", 32'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 32'b11);
    check("t6_push",   32'({wr_en, tx_data}), 32'h13C);
    check("t6_rdata",  bus.S_AXI_RDATA, 32'h15);
    check("t6_resps",  32'({bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 32'd0);
    repeat (2) @(negedge clk);
    check("t6_closed", 32'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 32'b00);

    // randomized traffic against the register model
    for (int it = 0; it < 40; it++) begin
      p_empty = empty; p_txe = tx_empty;
      @(posedge clk); #1;
      empty    = 1'($urandom_range(0, 1));
      tx_empty = 1'($urandom_range(0, 1));
      full     = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom_range(0, 255));
      exp_irq  = m_intr && ((p_empty && !empty) || (!p_txe && tx_empty));
      @(posedge clk);
      @(negedge clk);
      check("rnd_irq", 32'(irq), 32'(exp_irq));

      addr = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 0) begin
        wd   = $urandom;
        strb = 4'($urandom_range(0, 15));
        exp_resp = RESP_OKAY; exp_push = 1'b0; exp_rtx = 1'b0; exp_rrx = 1'b0;
        if (strb[0]) begin
          if (addr[3:2] == 2'd1) begin
            if (full) exp_resp = RESP_SLVERR;
            else      exp_push = 1'b1;
          end else if (addr[3:2] == 2'd3) begin
            exp_rtx = wd[0]; exp_rrx = wd[1];
            m_en_rx = wd[2]; m_en_tx = wd[3]; m_intr = wd[4];
          end else begin
            exp_resp = RESP_SLVERR;
          end
        end
        axi_write(addr, wd, strb, ok, b_n1, resp, n_wr, txd, n_rtx, n_rrx);
        check("rnd_w_bvalid", 32'(b_n1),  32'd1);
        check("rnd_w_bresp",  32'(resp),  32'(exp_resp));
        check("rnd_w_push",   32'(n_wr),  32'(exp_push));
        if (exp_push) check("rnd_w_txdata", 32'(txd), 32'(wd[7:0]));
        check("rnd_w_clears", 32'({n_rtx[1:0], n_rrx[1:0]}), 32'({1'b0, exp_rtx, 1'b0, exp_rrx}));
        check("rnd_w_ctrl",   32'({en_rx, en_tx}), 32'({m_en_rx, m_en_tx}));
      end else begin
        hold = $urandom_range(0, 2);
        exp_data = 32'h0; exp_resp = RESP_OKAY;
        case (addr[3:2])
          2'd0: if (empty) exp_resp = RESP_SLVERR; else exp_data = 32'(rx_data);
          2'd2: exp_data = 32'(!empty) + 32'(tx_empty) * 4 + 32'(full) * 8 + 32'(m_intr) * 16;
          default: exp_resp = RESP_SLVERR;
        endcase
        exp_q.push_back(exp_data);
        axi_read(addr, hold, ok, r_n1, data, resp, n_rd, stable, done);
        check("rnd_r_rvalid", 32'(r_n1),   32'd1);
        check("rnd_r_rdata",  data,        exp_q.pop_front());
        check("rnd_r_rresp",  32'(resp),   32'(exp_resp));
        check("rnd_r_pop",    32'(n_rd),   32'((addr[3:2] == 2'd0) && !empty));
        check("rnd_r_stable", 32'(stable), 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
